// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle MIPS-subset controller:
//   - state_t     : FSM state encoding (also exported on state_dbg)
//   - OP_*        : supported IR[31:26] opcodes
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU control encodings
//   - ctrl_word_t : the full control word driven toward the datapath
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the controller and the datapath.
//   Datapath -> controller : opcode (IR[31:26]), mem_ready
//   Controller -> datapath : all mux selects, write enables and the
//                            one-cycle illegal-opcode pulse
// Handshake: mem_ready is a completion strobe for whatever access the
// controller is currently requesting (MemRead or MemWrite). The request is
// held stable until the cycle mem_ready=1 is seen; that cycle completes it.
// Modports: master = controller, slave = datapath.
// ---------------------------------------------------------------------------
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal
    );

endinterface

// File: rtl/multicycle_control_decode.sv
// ---------------------------------------------------------------------------
// ctrl_out_decode
// Combinational state -> control-word decode.
//   rst       : when 1, every control output is forced to 0
//   state     : current FSM state (registered)
//   mem_ready : gates IRWrite/PCWrite in FETCH only
//   ctrl      : control word toward the datapath
// Everything except the FETCH enables is a pure function of state, so the
// control word never depends on opcode directly.
// ---------------------------------------------------------------------------
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.iord      = 1'b0;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    // PC+4 and IR are captured only on the completing cycle.
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Speculative branch target into ALUOut.
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_ILLEGAL: begin
                    ctrl.illegal = 1'b1;
                end
                default: begin
                    // Unreachable codes drive nothing.
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore sequencer for the multi-cycle MIPS-subset datapath.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : controller side of multicycle_control_if (opcode/mem_ready
//               in, control word out)
//   retired   : retired-instruction count, wraps modulo 2^CNT_W
//   state_dbg : current state encoding
// An instruction retires on the edge that leaves its final state; an
// illegal opcode passes through ILLEGAL and does not retire.
// ---------------------------------------------------------------------------
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state_dbg
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    ctrl_word_t         ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // Only lw/sw can reach MEMADR, so anything not lw is sw.
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    ctrl_out_decode u_decode (
        .rst       (rst),
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.illegal     = ctrl.illegal;

    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Instruction-level reference: each instruction is expanded into the list of
// states it should visit (with its stall cycles), and the expected control
// word for every cycle is taken from a per-state table. Retired count is
// modelled as "instructions completed so far", modulo 2^CNT_W.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } tb_ctrl_t;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    multicycle_control_if bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ret = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word per state, straight from the output table.
    function automatic tb_ctrl_t exp_ctrl(input int st, input bit mr);
        tb_ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'd1; c.ir_write = mr; c.pc_write = mr; end
            1:  begin c.alu_src_b = 2'd3; end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            3:  begin c.mem_read = 1; c.iord = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.iord = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'd2; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_cond = 1; c.pc_source = 2'd1; end
            9:  begin c.pc_write = 1; c.pc_source = 2'd2; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            11: begin c.reg_write = 1; end
            12: begin c.illegal = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic tb_ctrl_t observed();
        tb_ctrl_t c;
        c.pc_write      = bus.PCWrite;
        c.pc_write_cond = bus.PCWriteCond;
        c.iord          = bus.IorD;
        c.mem_read      = bus.MemRead;
        c.mem_write     = bus.MemWrite;
        c.ir_write      = bus.IRWrite;
        c.mem_to_reg    = bus.MemtoReg;
        c.reg_dst       = bus.RegDst;
        c.reg_write     = bus.RegWrite;
        c.alu_src_a     = bus.ALUSrcA;
        c.alu_src_b     = bus.ALUSrcB;
        c.alu_op        = bus.ALUOp;
        c.pc_source     = bus.PCSource;
        c.illegal       = bus.illegal;
        return c;
    endfunction

    // One clock cycle: called just after a posedge, drives inputs,
    // checks on the falling edge, returns just after the next posedge.
    task automatic do_cycle(input int st, input bit mr, input bit rst_v);
        tb_ctrl_t exp_c, got_c;
        int n_we;
        bus.mem_ready = mr;
        rst = rst_v;
        @(negedge clk);
        got_c = observed();
        exp_c = rst_v ? tb_ctrl_t'('0) : exp_ctrl(st, mr);
        check($sformatf("state st=%0d", st), 32'(state_dbg), 32'(st));
        check($sformatf("ctrl st=%0d mr=%0d rst=%0d", st, mr, rst_v), 32'(got_c), 32'(exp_c));
        check($sformatf("retired st=%0d", st), 32'(retired), 32'(model_ret % (1 << CNT_W)));
        check("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
        n_we = int'(bus.RegWrite) + int'(bus.MemWrite) + int'(bus.IRWrite);
        check("we_onehot", 32'(n_we > 1), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its expected state walk and run it.
    task automatic run_instr(input logic [5:0] op, input int f_stall, input int m_stall);
        int st_q[$];
        bit mr_q[$];
        bit is_illegal;
        is_illegal = 1'b0;
        bus.opcode = op;
        for (int i = 0; i < f_stall; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'b100011: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < m_stall; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
                st_q.push_back(3); mr_q.push_back(1'b1);
                st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            6'b101011: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < m_stall; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
                st_q.push_back(5); mr_q.push_back(1'b1);
            end
            6'b000000: begin
                st_q.push_back(6); mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(7); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            6'b000100: begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
            6'b000010: begin st_q.push_back(9); mr_q.push_back(1'($urandom_range(0, 1))); end
            6'b001000: begin
                st_q.push_back(10); mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            default: begin
                st_q.push_back(12); mr_q.push_back(1'($urandom_range(0, 1)));
                is_illegal = 1'b1;
            end
        endcase
        foreach (st_q[i]) do_cycle(st_q[i], mr_q[i], 1'b0);
        if (!is_illegal) model_ret++;
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011;
        legal_ops[2] = 6'b101011; legal_ops[3] = 6'b000100;
        legal_ops[4] = 6'b000010; legal_ops[5] = 6'b001000;

        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000000;
        @(posedge clk);
        #1;
        do_cycle(0, 1'b1, 1'b1);
        do_cycle(0, 1'b1, 1'b1);

        // directed: lw, stalled sw, fetch-stalled R-type, beq/j/addi, illegal
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000000, 2, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b111111, 0, 0);

        // reset while a load is waiting in MEMRD
        bus.opcode = 6'b100011;
        do_cycle(0, 1'b1, 1'b0);
        do_cycle(1, 1'b1, 1'b0);
        do_cycle(2, 1'b1, 1'b0);
        do_cycle(3, 1'b0, 1'b0);
        do_cycle(3, 1'b1, 1'b1);
        model_ret = 0;

        // random stream; long enough to wrap the narrow retire counter
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        run_instr(6'b000000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencer for the multi-cycle MIPS-subset datapath: one shared instruction/data memory, one ALU, PC/IR/A/B/ALUOut registers.
- Moore FSM with memory-ready stalls. Drives every datapath mux select and write enable.
- Counts retired instructions for performance checks.
- Sits beside the datapath top; consumes IR opcode and memory handshake only.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26] (valid from DECODE onward)
- mem_ready  input  1  shared memory has completed the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- ALUOp  output  2  0 = add, 1 = sub, 2 = funct, 3 = unused
- PCSource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal  output  1  one-cycle pulse on unsupported opcode
- retired  output  CNT_W  retired-instruction count
- state_dbg  output  4  current state encoding

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=12.
  - Codes 13–15 are unreachable and recover to FETCH.
- Reset:
  - rst sampled at posedge: state <= FETCH, retired <= 0.
  - While rst=1, all control outputs are forced to 0, including in the FETCH state.
  - rst overrides any in-progress access; no write enable may be asserted in a cycle where rst=1.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and PCWrite assert only when mem_ready=1, and the FSM then advances to DECODE. Otherwise it stays in FETCH with the PC unchanged.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH, retire.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1. MemWrite stays asserted and stable while waiting. -> FETCH, retire on the mem_ready cycle.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH, retire.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. -> FETCH, retire.
- JUMP: PCWrite=1, PCSource=2. -> FETCH, retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH, retire.
- ILLEGAL: illegal=1 for exactly one cycle. -> FETCH, no retire. The instruction behaves as a NOP because PC+4 was already written in FETCH.
- Retire counter:
  - "Retire" means retired increments by 1 on the clock edge that leaves the final state of an instruction.
  - retired wraps modulo 2^CNT_W.
- Output timing:
  - All outputs other than the mem_ready-gated enables are pure decodes of the state register.
  - IRWrite/PCWrite in FETCH are combinational AND with mem_ready.
  - No output may glitch-depend on opcode except through the registered next-state.
- Write-enable exclusivity: MemRead and MemWrite are never both 1. At most one of RegWrite/MemWrite/IRWrite is asserted per cycle.
- Instruction latency (CPI), with mem_ready tied high:
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j = 3
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - state enum
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module ctrl_out_decode: combinational state -> control-word decode, including the rst forcing.
- The FSM register, next-state logic and retire counter stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_ready=1 -> all enables 0, state_dbg=0, retired=0. First cycle after rst falls shows MemRead=1, IRWrite=1, PCWrite=1.
- lw stream: opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; retired increments 0->1 after 5 cycles.
- Stalls: sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles, IorD=1 throughout; retired increments only after mem_ready=1; total 7 cycles.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH -> IRWrite/PCWrite stay 0 for those 2 cycles, then pulse for 1 cycle.
- Branch/jump/addi: beq -> 0,1,8 with PCWriteCond=1, ALUOp=1; j -> 0,1,9 with PCSource=2; addi -> 0,1,10,11 with RegDst=0. Three instructions in 10 cycles give retired=3.
- Illegal plus mid-reset: opcode=111111 -> state 12, illegal pulses 1 cycle, retired unchanged. Asserting rst while in MEMRD -> next state FETCH, RegWrite never asserted.
